// File: rtl/transmissor_paridade_par.sv
// Serial even-parity transmitter.
// A word captured on a one-cycle start strobe is shifted out LSB first, then
// one parity bit is appended so that every WIDTH+1 bit frame holds an even
// number of ones. Outputs are decoded from registered state only.
module transmissor_paridade_par #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic             out_bit,
    output logic             bit_valid,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DATA   = 2'd1;
    localparam logic [1:0] PARITY = 2'd2;

    // Counter value seen on the edge that shifts out the last data bit.
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic             par_q,   par_d;
    logic             done_q,  done_d;

    // Next-state logic: accept in IDLE, shift and accumulate parity in DATA,
    // send the parity bit for one cycle, then flag completion.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = DATA;
                    shreg_d = data_in;
                    cnt_d   = '0;
                    par_d   = 1'b0;
                end
            end
            DATA: begin
                par_d   = par_q ^ shreg_q[0];
                shreg_d = shreg_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = PARITY;
                end
            end
            PARITY: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset abandons any partial frame without sending parity.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            par_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            done_q  <= done_d;
        end
    end

    // Output decode; the line is held low in IDLE so no stray ones appear
    // between frames.
    always_comb begin
        out_bit   = 1'b0;
        bit_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            DATA: begin
                out_bit   = shreg_q[0];
                bit_valid = 1'b1;
                busy      = 1'b1;
            end
            PARITY: begin
                out_bit   = par_q;
                bit_valid = 1'b1;
                busy      = 1'b1;
            end
            default: begin
                out_bit   = 1'b0;
                bit_valid = 1'b0;
                busy      = 1'b0;
            end
        endcase
    end

    assign done = done_q;

endmodule
